cnn_window_feeder: RTL and testbench
====================================

CNN_WINDOW_FEEDER -- requirements
Module: cnn_window_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 17, meaning the signed sample width, matching the 2*WIDTH-1 cell state/output width.
REQ-002 SHALL have parameter IMG_W, default 8, meaning the image columns (minimum 3).
REQ-003 SHALL have parameter IMG_H, default 8, meaning the image rows (minimum 3).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, the reset, synchronous and active-high.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DATA_W, signed): a row-major pixel stream, one frame = IMG_W*IMG_H beats.
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the window handshake.
REQ-008 SHALL have port out_win, output, 9*DATA_W: taps W1..W9, W1 in the LSBs; W1 top-left, W5 centre, W9 bottom-right, row-major, directly mappable onto cell Y1..Y9 / U1..U9.
REQ-009 SHALL have ports out_row (output, $clog2(IMG_H)) and out_col (output, $clog2(IMG_W)): the window centre coordinates.
REQ-010 SHALL have port out_last, output, 1: high on the final window of a frame.

Function
REQ-011 SHALL emit exactly IMG_W*IMG_H windows per frame, one per pixel, in row-major centre order.
REQ-012 SHALL store two previous rows in line buffers (2*IMG_W entries) plus a 3x3 shift register; no full-frame buffer.
REQ-013 SHALL use states IDLE -> FILL -> STREAM -> FLUSH -> IDLE:
- IDLE -> FILL on the first accepted pixel.
- FILL -> STREAM when pixel (1,1) is accepted.
- STREAM -> FLUSH when the last frame pixel is accepted.
- FLUSH -> IDLE when the out_last window is accepted.
REQ-014 SHALL make the window centred at (r,c) eligible once pixel (min(r+1,IMG_H-1), min(c+1,IMG_W-1)) is accepted, and assert out_valid within 2 cycles of that acceptance when out_ready is high.
REQ-015 SHALL hold out_valid, out_win, out_row, out_col and out_last stable while out_valid=1 and out_ready=0.
REQ-016 SHALL count a transfer on each cycle where valid and ready are both high; a simultaneous input accept and output accept in one cycle SHALL both take effect.
REQ-017 SHALL deassert in_ready when the accepted-pixel count minus the emitted-window count reaches IMG_W+2, and during FLUSH.
REQ-018 SHALL pass pixel values through unmodified; there is no arithmetic on samples.
REQ-019 SHALL wrap the column counter at IMG_W-1 to 0 and increment the row counter; after the last window, the row and column counters SHALL return to 0 for the next frame.
REQ-020 SHALL allow back-to-back frames: the first pixel of frame N+1 may be accepted in the cycle FLUSH exits to IDLE, and not before.

Reset
REQ-021 SHALL, on rst=1 at a clock edge, clear in_ready, out_valid, out_last, out_row, out_col and out_win to 0, enter IDLE and zero all counters.
REQ-022 SHALL discard any partially received frame on rst mid-frame; the line buffer contents after reset are don't-care and never appear on out_win before being rewritten.
REQ-023 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-024 SHALL, when macro WIN_ZERO_PAD_EN is defined, drive every out-of-image tap to 0 (fixed zero boundary).
REQ-025 SHALL, when WIN_ZERO_PAD_EN is undefined, give each out-of-image tap the value of the nearest in-image pixel (edge replicate).

Verification
REQ-026 SHALL cover: 4x4 frame, pixel = index 0..15, WIN_ZERO_PAD_EN defined, out_ready=1 -> window (0,0) = 0,0,0,0,0,1,0,4,5; window (3,3) = 10,11,0,14,15,0,0,0,0; out_last only on (3,3).
REQ-027 SHALL cover: same stimulus, macro undefined -> window (0,0) = 0,0,1,0,0,1,4,4,5; window (1,1) = 0,1,2,4,5,6,8,9,10.
REQ-028 SHALL cover: out_ready=0 for 20 cycles mid-frame (4x4) -> in_ready falls after accepted-minus-emitted reaches 6; out_win is stable; no window is lost or duplicated (16 total).
REQ-029 SHALL cover: rst pulse after 7 pixels, then a full fresh frame -> exactly 16 windows, all matching the fresh data.
REQ-030 SHALL cover: two frames back-to-back with in_valid held at 1 -> 32 windows, out_last on windows 16 and 32, and second-frame coordinates restarting at (0,0).

Source files
------------

// File: rtl/cnn_window_feeder.sv
// cnn_window_feeder
// Turns a row-major pixel stream into one 3x3 neighbourhood window per pixel,
// with the taps laid out W1 (top-left, LSBs) .. W9 (bottom-right).
// Only the last two image rows plus three pixels are kept.
// Optional macro WIN_ZERO_PAD_EN: out-of-image taps read as 0.
// When the macro is undefined, out-of-image taps replicate the nearest edge pixel.
module cnn_window_feeder #(
    parameter int DATA_W = 17,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [DATA_W-1:0]    in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [9*DATA_W-1:0]         out_win,
    output logic [$clog2(IMG_H)-1:0]    out_row,
    output logic [$clog2(IMG_W)-1:0]    out_col,
    output logic                        out_last
);

    localparam int RW    = $clog2(IMG_H);
    localparam int CW    = $clog2(IMG_W);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int AW    = $clog2(NPIX + 1);
    localparam int DEPTH = 2 * IMG_W + 3;
    localparam int HW    = $clog2(DEPTH);

    localparam logic [AW-1:0] NPIX_C   = AW'(NPIX);
    localparam logic [AW-1:0] LAST_WIN = AW'(NPIX - 1);
    localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);
    localparam logic [AW-1:0] FILL_END = AW'(IMG_W + 1);
    localparam logic [AW-1:0] MAX_LAG  = AW'(IMG_W + 2);
    localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;

    state_t                     state;
    logic                       run;
    logic [AW-1:0]              acc_cnt;
    logic [AW-1:0]              emit_cnt;
    logic [RW-1:0]              nxt_row;
    logic [CW-1:0]              nxt_col;
    logic signed [DATA_W-1:0]   hist [DEPTH];

    logic                       in_accept;
    logic                       out_accept;
    logic                       eligible;
    logic                       load;
    logic [RW-1:0]              need_row;
    logic [CW-1:0]              need_col;
    logic [9*DATA_W-1:0]        win_next;

    assign in_accept  = in_valid && in_ready;
    assign out_accept = out_valid && out_ready;
    assign load       = (emit_cnt != NPIX_C) && (!out_valid || out_ready) && eligible;

    // Input backpressure: cap the backlog of un-emitted pixels, and during flush only reopen as the last window leaves.
    always_comb begin
        in_ready = 1'b0;
        if (run) begin
            if (state == FLUSH) begin
                in_ready = out_valid && out_ready && out_last;
            end else begin
                in_ready = (acc_cnt - emit_cnt) < MAX_LAG;
            end
        end
    end

    // The next window is ready once the pixel below-right of its centre (clamped to the image) has arrived.
    always_comb begin
        need_row = (nxt_row == ROW_MAX) ? ROW_MAX : nxt_row + 1'b1;
        need_col = (nxt_col == COL_MAX) ? COL_MAX : nxt_col + 1'b1;
        eligible = int'(acc_cnt) >= (int'(need_row) * IMG_W + int'(need_col) + 1);
    end

    // Gather the nine taps of the next window from the pixel history; hist[0] is the newest pixel.
    always_comb begin
        int rr;
        int cc;
        int off;
        logic signed [DATA_W-1:0] tap;
`ifdef WIN_ZERO_PAD_EN
        logic in_img;
`endif
        win_next = '0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                rr = int'(nxt_row) + dy - 1;
                cc = int'(nxt_col) + dx - 1;
`ifdef WIN_ZERO_PAD_EN
                in_img = (rr >= 0) && (rr < IMG_H) && (cc >= 0) && (cc < IMG_W);
`endif
                if (rr < 0) rr = 0;
                if (rr > IMG_H - 1) rr = IMG_H - 1;
                if (cc < 0) cc = 0;
                if (cc > IMG_W - 1) cc = IMG_W - 1;
                off = int'(acc_cnt) - 1 - (rr * IMG_W + cc);
                if ((off < 0) || (off >= DEPTH)) off = 0;
                tap = hist[off[HW-1:0]];
`ifdef WIN_ZERO_PAD_EN
                if (!in_img) tap = '0;
`endif
                win_next[(dy*3 + dx)*DATA_W +: DATA_W] = tap;
            end
        end
    end

    // Pixel history shift register; contents are never read before being rewritten, so no reset is needed.
    always_ff @(posedge clk) begin
        if (in_accept) begin
            hist[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

    // Frame sequencing, counters and the registered output window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            run       <= 1'b0;
            acc_cnt   <= '0;
            emit_cnt  <= '0;
            nxt_row   <= '0;
            nxt_col   <= '0;
            out_valid <= 1'b0;
            out_win   <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
        end else begin
            run <= 1'b1;

            if (load) begin
                out_valid <= 1'b1;
                out_win   <= win_next;
                out_row   <= nxt_row;
                out_col   <= nxt_col;
                out_last  <= (emit_cnt == LAST_WIN);
                emit_cnt  <= emit_cnt + 1'b1;
                if (nxt_col == COL_MAX) begin
                    nxt_col <= '0;
                    nxt_row <= (nxt_row == ROW_MAX) ? '0 : nxt_row + 1'b1;
                end else begin
                    nxt_col <= nxt_col + 1'b1;
                end
            end else if (out_accept) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            if (out_accept && out_last) begin
                emit_cnt <= '0;
                acc_cnt  <= in_accept ? AW'(1) : '0;
            end else if (in_accept) begin
                acc_cnt <= acc_cnt + 1'b1;
            end

            case (state)
                IDLE:    if (in_accept) state <= FILL;
                FILL:    if (in_accept && (acc_cnt == FILL_END)) state <= STREAM;
                STREAM:  if (in_accept && (acc_cnt == LAST_PIX)) state <= FLUSH;
                FLUSH:   if (out_accept && out_last) state <= in_accept ? FILL : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_window_feeder.sv
// tb_cnn_window_feeder
// Randomised scoreboard bench for cnn_window_feeder on a 4x4 image.
// The reference model builds each window straight from a 2-D view of the frame.
// Works with WIN_ZERO_PAD_EN defined or undefined.
module tb_cnn_window_feeder;

    localparam int DW = 17;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NP = W * H;

    logic                clk;
    logic                rst;
    logic                inValid;
    logic                inReady;
    logic signed [DW-1:0] inData;
    logic                outValid;
    logic                outReady;
    logic [9*DW-1:0]     outWin;
    logic [1:0]          outRow;
    logic [1:0]          outCol;
    logic                outLast;

    cnn_window_feeder #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_win   (outWin),
        .out_row   (outRow),
        .out_col   (outCol),
        .out_last  (outLast)
    );

    typedef struct packed {
        logic [9*DW-1:0] win;
        logic [1:0]      row;
        logic [1:0]      col;
        logic            last;
    } exp_t;

    exp_t            expQ[$];
    logic [DW-1:0]   streamPix[$];
    logic [DW-1:0]   framePix[NP];
    logic [9*DW-1:0] capWin[NP];
    int              capCount = 0;
    int              total = 0;
    int              bad = 0;
    int              readyMode = 0;
    int              accepted = 0;
    int              transferred = 0;

    logic            prevStall = 1'b0;
    logic [158:0]    prevOut = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer side: ready always high, always low, or random.
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       outReady = 1'b1;
            1:       outReady = 1'b0;
            default: outReady = (($urandom % 4) != 0);
        endcase
    end

    task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference window: 3x3 neighbourhood of (r,c) taken from the 2-D frame.
    function automatic logic [9*DW-1:0] refWindow(input int r, input int c);
        logic [9*DW-1:0] w;
        logic [DW-1:0]   v;
        int rr;
        int cc;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            rr = r + (k / 3) - 1;
            cc = c + (k % 3) - 1;
`ifdef WIN_ZERO_PAD_EN
            if (rr < 0 || rr >= H || cc < 0 || cc >= W) v = '0;
            else v = framePix[rr*W + cc];
`else
            if (rr < 0) rr = 0;
            if (rr >= H) rr = H - 1;
            if (cc < 0) cc = 0;
            if (cc >= W) cc = W - 1;
            v = framePix[rr*W + cc];
`endif
            w[k*DW +: DW] = v;
        end
        return w;
    endfunction

    function automatic logic [9*DW-1:0] packWin(input int a0, input int a1, input int a2,
                                                input int a3, input int a4, input int a5,
                                                input int a6, input int a7, input int a8);
        int t[9];
        logic [9*DW-1:0] w;
        t = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        w = '0;
        for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(t[k]);
        return w;
    endfunction

    // Append the current frame to the pixel stream and its windows to the scoreboard.
    task automatic queueFrame();
        exp_t e;
        for (int i = 0; i < NP; i++) begin
            streamPix.push_back(framePix[i]);
            e.win  = refWindow(i / W, i % W);
            e.row  = 2'(i / W);
            e.col  = 2'(i % W);
            e.last = (i == NP - 1);
            expQ.push_back(e);
        end
    endtask

    function automatic void randomFrame();
        for (int i = 0; i < NP; i++) framePix[i] = DW'($urandom);
    endfunction

    // Drive every queued pixel; in_valid stays high between pixels unless a gap is inserted.
    task automatic applyStimulus(input bit gaps);
        logic [DW-1:0] v;
        bit got;
        while (streamPix.size() > 0) begin
            v = streamPix.pop_front();
            inValid = 1'b1;
            inData  = v;
            got = 1'b0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (inReady) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                total++;
                bad++;
                $display("[TB] FAIL pixel_accept_timeout: got in_ready=0 expected in_ready=1 within 200 cycles");
            end
            @(posedge clk);
            #1;
            if (gaps && (($urandom % 3) == 0)) begin
                inValid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        inValid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        for (int t = 0; t < 400; t++) begin
            if (expQ.size() == 0) break;
            @(negedge clk);
        end
        checkOutput(name, 160'(expQ.size()), 160'(0));
        expQ.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every transfer, and check that a stalled window holds still.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("hold_stable", 160'({outValid, outWin, outRow, outCol, outLast}),
                            160'({1'b1, prevOut[157:0]}));
            end
            if (inValid && inReady) accepted++;
            if (outValid && outReady) begin
                transferred++;
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_window: got row %0d col %0d expected no window", outRow, outCol);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("window_taps", 160'(outWin), 160'(e.win));
                    checkOutput("window_coord_last", 160'({outRow, outCol, outLast}),
                                160'({e.row, e.col, e.last}));
                end
                if (capCount < NP) begin
                    capWin[capCount] = outWin;
                    capCount++;
                end
            end
            prevStall = outValid && !outReady;
            prevOut   = {outValid, outWin, outRow, outCol, outLast};
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int x;
        rst     = 1'b1;
        inValid = 1'b0;
        inData  = '0;
        readyMode = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 160'(inReady), 160'(0));
        checkOutput("reset_out_valid", 160'(outValid), 160'(0));
        checkOutput("reset_row_col_last", 160'({outRow, outCol, outLast}), 160'(0));
        checkOutput("reset_out_win", 160'(outWin), 160'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_reset", 160'(inReady), 160'(1));

        $display("[TB] index frame, ready held high");
        for (int i = 0; i < NP; i++) framePix[i] = DW'(i);
        capCount = 0;
        queueFrame();
        applyStimulus(1'b0);
        waitDrain("drain_index_frame");
        checkOutput("index_window_count", 160'(capCount), 160'(NP));
`ifdef WIN_ZERO_PAD_EN
        checkOutput("index_win_0_0", 160'(capWin[0]), 160'(packWin(0, 0, 0, 0, 0, 1, 0, 4, 5)));
        checkOutput("index_win_3_3", 160'(capWin[15]), 160'(packWin(10, 11, 0, 14, 15, 0, 0, 0, 0)));
`else
        checkOutput("index_win_0_0", 160'(capWin[0]), 160'(packWin(0, 0, 1, 0, 0, 1, 4, 4, 5)));
        checkOutput("index_win_3_3", 160'(capWin[15]), 160'(packWin(10, 11, 11, 14, 15, 15, 14, 15, 15)));
`endif
        checkOutput("index_win_1_1", 160'(capWin[5]), 160'(packWin(0, 1, 2, 4, 5, 6, 8, 9, 10)));

        $display("[TB] random frames, random ready and input gaps");
        for (int f = 0; f < 3; f++) begin
            readyMode = 2;
            randomFrame();
            queueFrame();
            applyStimulus(1'b1);
            waitDrain("drain_random_frame");
        end

        $display("[TB] output stall for 20 cycles");
        readyMode = 1;
        repeat (2) @(posedge clk);
        #1;
        randomFrame();
        queueFrame();
        n = accepted;
        x = transferred;
        fork
            applyStimulus(1'b0);
            begin
                repeat (20) @(posedge clk);
                #1;
                checkOutput("stall_in_ready_low", 160'(inReady), 160'(0));
                checkOutput("stall_backlog_in_range",
                            160'((accepted - n) >= W + 2 && (accepted - n) <= W + 3), 160'(1));
                checkOutput("stall_no_transfer", 160'(transferred - x), 160'(0));
                readyMode = 0;
            end
        join
        waitDrain("drain_stall_frame");

        $display("[TB] reset in the middle of a frame");
        readyMode = 1;
        repeat (2) @(posedge clk);
        #1;
        randomFrame();
        for (int i = 0; i < 7; i++) streamPix.push_back(framePix[i]);
        applyStimulus(1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midframe_reset_out_valid", 160'(outValid), 160'(0));
        readyMode = 0;
        randomFrame();
        n = transferred;
        queueFrame();
        applyStimulus(1'b1);
        waitDrain("drain_after_reset");
        checkOutput("after_reset_window_count", 160'(transferred - n), 160'(NP));

        $display("[TB] two frames back to back");
        readyMode = 0;
        n = transferred;
        randomFrame();
        queueFrame();
        randomFrame();
        queueFrame();
        applyStimulus(1'b0);
        waitDrain("drain_back_to_back");
        checkOutput("back_to_back_window_count", 160'(transferred - n), 160'(2 * NP));

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
